// File: rtl/fb_ctrl_pkg.sv
// rtl/fb_ctrl_pkg.sv - shared types and frame geometry for the frame-buffer access controller
package fb_ctrl_pkg;

   typedef enum logic [1:0] {LIVE, ARM, FILL, FROZEN} fb_state_t;
   typedef enum logic {OWN_DISP, OWN_DEC} fb_owner_t;

   localparam int FB_W     = 320;
   localparam int FB_H     = 240;
   localparam int FB_DEPTH = FB_W * FB_H;

endpackage

// File: rtl/fb_rd_return_pipe.sv
// rtl/fb_rd_return_pipe.sv - tracks issued port-B reads through BRAM latency and steers
// returning data to the display or decoder.
module fb_rd_return_pipe
   import fb_ctrl_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              en_in,
   input  fb_owner_t         owner_in,
   input  logic [DATA_W-1:0] ram_dout_in,
   output logic              disp_valid_out,
   output logic [DATA_W-1:0] disp_data_out,
   output logic              dec_rvalid_out,
   output logic [DATA_W-1:0] dec_data_out
);

   logic [RD_LATENCY-1:0] vld;
   logic [RD_LATENCY-1:0] own_dec;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vld     <= '0;
         own_dec <= '0;
      end else begin
         vld[0]     <= en_in;
         own_dec[0] <= (owner_in == OWN_DEC);
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld[i]     <= vld[i-1];
            own_dec[i] <= own_dec[i-1];
         end
      end
   end

   // Data is forced to zero whenever its consumer has no valid beat.
   assign disp_valid_out = vld[RD_LATENCY-1] & ~own_dec[RD_LATENCY-1];
   assign dec_rvalid_out = vld[RD_LATENCY-1] &  own_dec[RD_LATENCY-1];
   assign disp_data_out  = disp_valid_out ? ram_dout_in : '0;
   assign dec_data_out   = dec_rvalid_out ? ram_dout_in : '0;

endmodule

// File: rtl/fb_access_ctrl.sv
// rtl/fb_access_ctrl.sv - frame-buffer write gating, snapshot sequencing and port-B arbitration.
// Optional forced release after HOLD_FRAMES frozen frames: define FBCTRL_TIMEOUT_EN.
module fb_access_ctrl
   import fb_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 17,
   parameter int DATA_W      = 16,
   parameter int RD_LATENCY  = 2,
   parameter int HOLD_FRAMES = 60
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              cam_we_in,
   input  logic              cam_frame_done_in,
   output logic              fb_we_out,
   input  logic              capture_req_in,
   input  logic              release_in,
   output logic              frozen_out,
   output logic              timeout_out,
   input  logic              disp_en_in,
   input  logic [ADDR_W-1:0] disp_addr_in,
   input  logic              dec_req_in,
   input  logic [ADDR_W-1:0] dec_addr_in,
   output logic              dec_gnt_out,
   output logic [ADDR_W-1:0] ram_addr_out,
   output logic              ram_en_out,
   input  logic [DATA_W-1:0] ram_dout_in,
   output logic              disp_valid_out,
   output logic [DATA_W-1:0] disp_data_out,
   output logic              dec_rvalid_out,
   output logic [DATA_W-1:0] dec_data_out
);

   fb_state_t state;
   fb_owner_t ram_owner;
   logic      timeout_hit;

   if (RD_LATENCY < 1 || RD_LATENCY > 4 || HOLD_FRAMES < 1 || (2 ** ADDR_W) < FB_DEPTH) begin : g_bad_cfg
      $error("fb_access_ctrl: unsupported parameter set");
   end

`ifdef FBCTRL_TIMEOUT_EN
   logic [7:0] frame_cnt;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         frame_cnt <= '0;
      end else if (state == FILL && cam_frame_done_in && !release_in) begin
         frame_cnt <= '0;
      end else if (state == FROZEN && cam_frame_done_in && frame_cnt != 8'hFF) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   // Fires on the frame_done that brings the frozen count up to HOLD_FRAMES.
   assign timeout_hit = frozen_out & cam_frame_done_in & ~release_in &
                        ((int'(frame_cnt) + 1) >= HOLD_FRAMES);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state       <= LIVE;
         frozen_out  <= 1'b0;
         timeout_out <= 1'b0;
      end else begin
         timeout_out <= 1'b0;
         case (state)
            LIVE: begin
               if (capture_req_in) state <= ARM;
            end
            ARM: begin
               if (release_in)             state <= LIVE;
               else if (cam_frame_done_in) state <= FILL;
            end
            FILL: begin
               if (release_in) begin
                  state <= LIVE;
               end else if (cam_frame_done_in) begin
                  state      <= FROZEN;
                  frozen_out <= 1'b1;
               end
            end
            FROZEN: begin
               if (release_in || timeout_hit) begin
                  state       <= LIVE;
                  frozen_out  <= 1'b0;
                  timeout_out <= timeout_hit;
               end
            end
            default: begin
               state      <= LIVE;
               frozen_out <= 1'b0;
            end
         endcase
      end
   end

   // The write coincident with FROZEN entry still sees FILL and passes.
   assign fb_we_out   = cam_we_in & (state != FROZEN);
   assign dec_gnt_out = dec_req_in & frozen_out & ~disp_en_in & ~release_in & ~timeout_hit;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ram_addr_out <= '0;
         ram_en_out   <= 1'b0;
         ram_owner    <= OWN_DISP;
      end else if (disp_en_in) begin
         ram_addr_out <= disp_addr_in;
         ram_en_out   <= 1'b1;
         ram_owner    <= OWN_DISP;
      end else if (dec_gnt_out) begin
         ram_addr_out <= dec_addr_in;
         ram_en_out   <= 1'b1;
         ram_owner    <= OWN_DEC;
      end else begin
         ram_en_out   <= 1'b0;
      end
   end

   fb_rd_return_pipe #(
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_return_pipe (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .en_in          (ram_en_out),
      .owner_in       (ram_owner),
      .ram_dout_in    (ram_dout_in),
      .disp_valid_out (disp_valid_out),
      .disp_data_out  (disp_data_out),
      .dec_rvalid_out (dec_rvalid_out),
      .dec_data_out   (dec_data_out)
   );

endmodule

// File: tb/tb_fb_access_ctrl.sv
// tb/tb_fb_access_ctrl.sv - randomized bench for fb_access_ctrl against a behavioural model.
// Honours FBCTRL_TIMEOUT_EN to match the design build.
`timescale 1ns/1ps
module tb_fb_access_ctrl;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 2;
   localparam int HOLD   = 3;
`ifdef FBCTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n_in;
   logic              cam_we_in, cam_frame_done_in, fb_we_out;
   logic              capture_req_in, release_in, frozen_out, timeout_out;
   logic              disp_en_in, dec_req_in, dec_gnt_out, ram_en_out;
   logic [ADDR_W-1:0] disp_addr_in, dec_addr_in, ram_addr_out;
   logic [DATA_W-1:0] ram_dout_in, disp_data_out, dec_data_out;
   logic              disp_valid_out, dec_rvalid_out;

   always #5 clk = ~clk;

   fb_access_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .HOLD_FRAMES(HOLD)
   ) dut (
      .clk_in(clk), .rst_n_in(rst_n_in),
      .cam_we_in(cam_we_in), .cam_frame_done_in(cam_frame_done_in), .fb_we_out(fb_we_out),
      .capture_req_in(capture_req_in), .release_in(release_in),
      .frozen_out(frozen_out), .timeout_out(timeout_out),
      .disp_en_in(disp_en_in), .disp_addr_in(disp_addr_in),
      .dec_req_in(dec_req_in), .dec_addr_in(dec_addr_in), .dec_gnt_out(dec_gnt_out),
      .ram_addr_out(ram_addr_out), .ram_en_out(ram_en_out), .ram_dout_in(ram_dout_in),
      .disp_valid_out(disp_valid_out), .disp_data_out(disp_data_out),
      .dec_rvalid_out(dec_rvalid_out), .dec_data_out(dec_data_out)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model: 0 live, 1 armed, 2 filling, 3 frozen; reads scheduled by return cycle.
   int                m_mode;
   int                m_held;
   bit                m_timeout;
   bit                m_en;
   logic [ADDR_W-1:0] m_addr;
   bit                sched_dec  [int];
   logic [DATA_W-1:0] sched_data [int];
   bit                hist_en    [int];
   logic [ADDR_W-1:0] hist_addr  [int];

   function automatic logic [DATA_W-1:0] mem(input logic [ADDR_W-1:0] a);
      if (a == 17'd76799) return 16'hF800;
      return a[DATA_W-1:0] ^ 16'h5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_held = 0; m_timeout = 1'b0; m_en = 1'b0; m_addr = '0;
      sched_dec.delete();
      sched_data.delete();
   endtask

   task automatic drive_bram();
      int k;
      k = cyc - RD_LAT;
      if (hist_en.exists(k) && hist_en[k]) ram_dout_in = mem(hist_addr[k]);
      else                                 ram_dout_in = 16'($urandom);
   endtask

   // One clock cycle: inputs already set by the caller; check, advance model, step clock.
   task automatic cycle();
      bit                to_hit, exp_gnt, v, isdec;
      logic [DATA_W-1:0] ed;
      int                due;
      #1;
      if (!rst_n_in) model_reset();
      to_hit  = TO_EN && m_mode == 3 && cam_frame_done_in && !release_in && (m_held + 1 >= HOLD);
      exp_gnt = dec_req_in && m_mode == 3 && !disp_en_in && !release_in && !to_hit;
      v       = sched_data.exists(cyc);
      isdec   = v && sched_dec[cyc];
      ed      = v ? sched_data[cyc] : '0;
      chk("fb_we",      32'(fb_we_out),      32'(cam_we_in && m_mode != 3));
      chk("frozen",     32'(frozen_out),     32'(m_mode == 3));
      chk("timeout",    32'(timeout_out),    32'(m_timeout));
      chk("dec_gnt",    32'(dec_gnt_out),    32'(exp_gnt));
      chk("ram_en",     32'(ram_en_out),     32'(m_en));
      chk("ram_addr",   32'(ram_addr_out),   32'(m_addr));
      chk("disp_valid", 32'(disp_valid_out), 32'(v && !isdec));
      chk("disp_data",  32'(disp_data_out),  32'((v && !isdec) ? ed : '0));
      chk("dec_rvalid", 32'(dec_rvalid_out), 32'(isdec));
      chk("dec_data",   32'(dec_data_out),   32'(isdec ? ed : '0));
      hist_en[cyc]   = ram_en_out;
      hist_addr[cyc] = ram_addr_out;
      if (rst_n_in) begin
         due = cyc + 1 + RD_LAT;
         if (disp_en_in) begin
            m_en = 1'b1; m_addr = disp_addr_in;
            sched_dec[due] = 1'b0; sched_data[due] = mem(disp_addr_in);
         end else if (exp_gnt) begin
            m_en = 1'b1; m_addr = dec_addr_in;
            sched_dec[due] = 1'b1; sched_data[due] = mem(dec_addr_in);
         end else begin
            m_en = 1'b0;
         end
         m_timeout = 1'b0;
         case (m_mode)
            0: if (capture_req_in) m_mode = 1;
            1: if (release_in) m_mode = 0; else if (cam_frame_done_in) m_mode = 2;
            2: if (release_in) m_mode = 0;
               else if (cam_frame_done_in) begin m_mode = 3; m_held = 0; end
            default: if (release_in) m_mode = 0;
               else if (to_hit) begin m_mode = 0; m_timeout = 1'b1; end
               else if (cam_frame_done_in) m_held++;
         endcase
      end
      cyc++;
      @(negedge clk);
      drive_bram();
   endtask

   task automatic go_frozen();
      capture_req_in = 1'b1; cycle(); capture_req_in = 1'b0;
      repeat (3) cycle();
      cam_frame_done_in = 1'b1; cycle(); cam_frame_done_in = 1'b0;
      repeat (5) cycle();
      cam_frame_done_in = 1'b1; cycle(); cam_frame_done_in = 1'b0;
   endtask

   initial begin
      rst_n_in = 1'b0; cam_we_in = 1'b0; cam_frame_done_in = 1'b0;
      capture_req_in = 1'b0; release_in = 1'b0; disp_en_in = 1'b0;
      dec_req_in = 1'b0; disp_addr_in = '0; dec_addr_in = '0; ram_dout_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      drive_bram();
      dec_req_in = 1'b1;
      cycle(); cycle();
      rst_n_in = 1'b1;

      // Live streaming, then capture at 10, frame boundaries at 100 and 200
      for (int c = 0; c <= 205; c++) begin
         cam_we_in = 1'b1;
         capture_req_in = (c == 10);
         cam_frame_done_in = (c == 100 || c == 200);
         dec_req_in = (c < 201);
         dec_addr_in = 17'(c);
         if (c == 5) begin
            #1;
            chk("lit_live_we",  32'(fb_we_out),   32'd1);
            chk("lit_live_gnt", 32'(dec_gnt_out), 32'd0);
         end
         if (c == 200) begin
            #1;
            chk("lit_last_px_we",    32'(fb_we_out),  32'd1);
            chk("lit_not_yet_frozen", 32'(frozen_out), 32'd0);
         end
         if (c == 201) begin
            #1;
            chk("lit_frozen_we", 32'(fb_we_out),  32'd0);
            chk("lit_frozen",    32'(frozen_out), 32'd1);
         end
         cycle();
      end
      capture_req_in = 1'b0; cam_frame_done_in = 1'b0;

      // Display beats decoder on the same cycle
      disp_en_in = 1'b1; disp_addr_in = 17'h1234; dec_req_in = 1'b1; dec_addr_in = 17'h1234;
      #1 chk("lit_gnt_blocked", 32'(dec_gnt_out), 32'd0);
      cycle();
      disp_en_in = 1'b0; dec_req_in = 1'b0;
      #1 chk("lit_disp_addr", 32'(ram_addr_out), 32'h1234);
      cycle(); cycle();
      #1;
      chk("lit_disp_valid", 32'(disp_valid_out), 32'd1);
      chk("lit_disp_data",  32'(disp_data_out),  32'h486E);
      cycle();

      // Decoder read of the last pixel
      dec_req_in = 1'b1; dec_addr_in = 17'd76799;
      #1 chk("lit_dec_gnt", 32'(dec_gnt_out), 32'd1);
      cycle();
      dec_req_in = 1'b0;
      #1 chk("lit_dec_addr", 32'(ram_addr_out), 32'd76799);
      cycle(); cycle();
      #1;
      chk("lit_dec_rvalid", 32'(dec_rvalid_out), 32'd1);
      chk("lit_dec_data",   32'(dec_data_out),   32'hF800);
      cycle();

      // Random arbitration while frozen
      for (int i = 0; i < 300; i++) begin
         cam_we_in    = 1'($urandom);
         disp_en_in   = ($urandom_range(0, 2) == 0);
         dec_req_in   = 1'($urandom);
         disp_addr_in = 17'($urandom_range(0, 76799));
         dec_addr_in  = 17'($urandom_range(0, 76799));
         cycle();
      end

      // Hold timeout after HOLD frame_done pulses
      disp_en_in = 1'b0; dec_req_in = 1'b1; cam_we_in = 1'b1;
      for (int p = 0; p < 3; p++) begin
         cam_frame_done_in = 1'b1;
         if (p == 2) begin
            #1 chk("lit_gnt_at_timeout", 32'(dec_gnt_out), TO_EN ? 32'd0 : 32'd1);
         end
         cycle();
         cam_frame_done_in = 1'b0;
         if (p < 2) repeat (4) cycle();
      end
      dec_req_in = 1'b0;
      #1;
      chk("lit_timeout_pulse", 32'(timeout_out), TO_EN ? 32'd1 : 32'd0);
      chk("lit_timeout_live",  32'(frozen_out),  TO_EN ? 32'd0 : 32'd1);
      chk("lit_timeout_we",    32'(fb_we_out),   TO_EN ? 32'd1 : 32'd0);
      cycle();
      #1 chk("lit_timeout_single", 32'(timeout_out), 32'd0);
      if (!TO_EN) begin
         release_in = 1'b1; cycle(); release_in = 1'b0;
      end
      cycle();

      // Reset while a decoder read is in flight
      go_frozen();
      dec_req_in = 1'b1; dec_addr_in = 17'd100;
      cycle();
      dec_req_in = 1'b0;
      cycle();
      rst_n_in = 1'b0;
      #1;
      chk("lit_rst_frozen", 32'(frozen_out), 32'd0);
      chk("lit_rst_ram_en", 32'(ram_en_out), 32'd0);
      cycle(); cycle();
      rst_n_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1 chk("lit_rst_no_rvalid", 32'(dec_rvalid_out), 32'd0);
         cycle();
      end

      // Fully random operation including occasional reset
      for (int i = 0; i < 3000; i++) begin
         rst_n_in          = ($urandom_range(0, 499) != 0);
         cam_we_in         = 1'($urandom);
         capture_req_in    = ($urandom_range(0, 19) == 0);
         cam_frame_done_in = ($urandom_range(0, 24) == 0);
         release_in        = ($urandom_range(0, 59) == 0);
         disp_en_in        = 1'($urandom);
         dec_req_in        = ($urandom_range(0, 9) < 7);
         disp_addr_in      = 17'($urandom_range(0, 76799));
         dec_addr_in       = 17'($urandom_range(0, 76799));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
